logic_gate_unit: RTL and testbench

Parametrised, registered multi-input logic gate with a valid/ready stream interface and a burst-reduction (accumulate) mode. It applies one of eight selectable bitwise operations across NUM_IN lanes of WIDTH bits per beat. It can either emit one result per beat or fold a whole burst into one result. It is the sequential, stream-capable successor to the team's single-bit fixed-function gates, and sits between stream producers and consumers in datapath test fixtures.

---
 rtl/logic_gate_unit.sv | 152 +++++++++++++++
 tb/tb_logic_gate_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// Registered multi-lane bitwise gate with valid/ready streaming and a burst-fold mode.
// Pass mode emits one result per beat; accumulate mode folds a whole burst into one result.
module logic_gate_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic [2:0]              op,
  input  logic                    acc_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    busy
);

  localparam logic StIdle  = 1'b0;
  localparam logic StAccum = 1'b1;

  logic             state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             acc_en_q, acc_en_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic             accept;
  logic [2:0]       cur_op;
  logic             cur_acc;
  logic [WIDTH-1:0] lane_and, lane_or, lane_xor;
  logic [WIDTH-1:0] beat_val, fold_val, combined, result;
  logic             invert;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Mid-burst the latched controls win; in IDLE every accept opens a burst.
  assign cur_op  = (state_q == StAccum) ? op_q : op;
  assign cur_acc = (state_q == StAccum) ? acc_en_q : acc_en;

  always_comb begin
    lane_and = in_data[WIDTH-1:0];
    lane_or  = in_data[WIDTH-1:0];
    lane_xor = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      lane_and = lane_and & in_data[k*WIDTH +: WIDTH];
      lane_or  = lane_or  | in_data[k*WIDTH +: WIDTH];
      lane_xor = lane_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // Ops 6/7 take lane0 only and fold across beats with AND.
  always_comb begin
    unique case (cur_op)
      3'd0, 3'd3: begin
        beat_val = lane_and;
        fold_val = acc_q & lane_and;
      end
      3'd1, 3'd4: begin
        beat_val = lane_or;
        fold_val = acc_q | lane_or;
      end
      3'd2, 3'd5: begin
        beat_val = lane_xor;
        fold_val = acc_q ^ lane_xor;
      end
      default: begin
        beat_val = in_data[WIDTH-1:0];
        fold_val = acc_q & in_data[WIDTH-1:0];
      end
    endcase
  end

  assign invert   = (cur_op >= 3'd3) && (cur_op <= 3'd6);
  assign combined = (state_q == StAccum) ? fold_val : beat_val;
  assign result   = combined ^ {WIDTH{invert}};
  assign cnt_next = (state_q == StIdle) ? CNT_W'(1) :
                    (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_en_d    = acc_en_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_beats_d = out_beats_q;
    if (accept) begin
      if (state_q == StIdle) begin
        op_d     = op;
        acc_en_d = acc_en;
      end
      if (!cur_acc || in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_last_d  = in_last;
        out_beats_d = cur_acc ? cnt_next : CNT_W'(1);
        state_d     = StIdle;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d   = combined;
        cnt_d   = cnt_next;
        state_d = StAccum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      acc_en_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_en_q    <= acc_en_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_beats = out_beats_q;
  assign busy      = (state_q == StAccum);

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed scenarios plus randomized bursts scored against a
// list-folding reference model. A CNT_W=2 copy shares the inputs to exercise beat saturation.
module tb_logic_gate_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_last, acc_en, out_ready;
  logic [15:0] in_data;
  logic [2:0]  op;
  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data, out_beats;
  logic        in_ready2, out_valid2, out_last2, busy2;
  logic [7:0]  out_data2;
  logic [1:0]  out_beats2;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         beats;
  } exp_t;

  exp_t       expq[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         model_on = 1'b0;
  bit         m_in_burst = 1'b0;
  int         m_op;
  bit         m_acc;
  logic [7:0] m_vals[$];

  always #5 clk = ~clk;

  logic_gate_unit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_beats(out_beats), .busy(busy)
  );

  logic_gate_unit #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .op(op), .acc_en(acc_en), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_last(out_last2), .out_beats(out_beats2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] lane_comb(input int o, input logic [7:0] a, input logic [7:0] b);
    if (o >= 6) return a;
    case (o % 3)
      0:       return a & b;
      1:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [7:0] fold2(input int o, input logic [7:0] x, input logic [7:0] y);
    if (o >= 6) return x & y;
    return lane_comb(o, x, y);
  endfunction

  // Collect the burst's per-beat values, reduce the list when it closes.
  task automatic model_beat();
    logic [7:0] r;
    exp_t       e;
    if (!m_in_burst) begin
      m_op  = int'(op);
      m_acc = acc_en;
    end
    m_vals.push_back(lane_comb(m_op, in_data[7:0], in_data[15:8]));
    if (!m_acc || in_last) begin
      r = m_vals[0];
      for (int i = 1; i < m_vals.size(); i++) r = fold2(m_op, r, m_vals[i]);
      if (m_op inside {[3:6]}) r = ~r;
      e.data  = r;
      e.last  = in_last;
      e.beats = m_vals.size();
      expq.push_back(e);
      m_vals.delete();
      m_in_burst = 1'b0;
    end else begin
      m_in_burst = 1'b1;
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (expq.size() == 0) begin
      check("spurious_out", out_valid, 0);
      return;
    end
    e = expq.pop_front();
    check("out_data", out_data, e.data);
    check("out_last", out_last, e.last);
    check("out_beats", out_beats, (e.beats > 255) ? 255 : e.beats);
    check("c2_out_valid", out_valid2, 1);
    check("c2_out_data", out_data2, e.data);
    check("c2_out_last", out_last2, e.last);
    check("c2_out_beats", out_beats2, (e.beats > 3) ? 3 : e.beats);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(output bit got);
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    check("c2_in_ready", in_ready2, !out_valid2 || out_ready);
    got = in_valid && in_ready;
    if (out_valid && out_ready) check_out();
    if (got && model_on) model_beat();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input bit acc, input bit last);
    bit got = 1'b0;
    in_data  = {b, a};
    op       = o;
    acc_en   = acc;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !got; t++) tick(got);
    if (!got) check("send_timeout", in_valid && in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input int n);
    exp_t e;
    e.data  = d;
    e.last  = l;
    e.beats = n;
    expq.push_back(e);
  endtask

  task automatic drain();
    bit got;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 30 && (expq.size() > 0 || out_valid); t++) tick(got);
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 8'h00);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_beats"}, out_beats, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [7:0] pass_exp [8];
  int         acc_ops [7];

  initial begin
    bit got;
    pass_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
    acc_ops  = '{0, 1, 2, 3, 4, 6, 7};
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; op = 3'd0; acc_en = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst_init");
    rst_n = 1'b1;
    @(negedge clk);

    // Pass mode, every op back-to-back.
    for (int o = 0; o < 8; o++) begin
      push(pass_exp[o], 1'b0, 1);
      send(8'hF0, 8'hCC, 3'(o), 1'b0, 1'b0);
      check("pass_valid", out_valid, 1);
    end
    drain();

    // XOR accumulate, 3 beats; later-beat op/acc_en must be ignored.
    push(8'h3F, 1'b1, 3);
    send(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
    check("xor_busy1", busy, 1);
    check("c2_xor_busy1", busy2, 1);
    send(8'h04, 8'h08, 3'd5, 1'b0, 1'b0);
    check("xor_busy2", busy, 1);
    send(8'h10, 8'h20, 3'd0, 1'b0, 1'b1);
    check("xor_busy_end", busy, 0);
    check("xor_valid", out_valid, 1);
    drain();

    // AND accumulate with op switched to OR on beat 2.
    push(8'h0C, 1'b1, 2);
    send(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
    send(8'h3C, 8'hFF, 3'd1, 1'b1, 1'b1);
    drain();

    // Backpressure: A stalls in the output register while B waits.
    push(8'h26, 1'b0, 1);
    push(8'hF5, 1'b0, 1);
    push(8'h00, 1'b1, 1);
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd2, 1'b0, 1'b0);
    in_data = {8'h0F, 8'hAA}; op = 3'd3; acc_en = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(got);
      check("bp_no_accept", got, 0);
      check("bp_hold_data", out_data, 8'h26);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    send(8'hAA, 8'h0F, 3'd3, 1'b0, 1'b0);
    send(8'h5A, 8'hA5, 3'd4, 1'b0, 1'b1);
    drain();

    // Single-beat NOR accumulate.
    push(8'hFF, 1'b1, 1);
    send(8'h00, 8'h00, 3'd4, 1'b1, 1'b1);
    check("single_busy", busy, 0);
    check("single_valid", out_valid, 1);
    drain();

    // Five-beat AND burst: full counter reports 5, CNT_W=2 copy saturates at 3.
    push(8'hB6, 1'b1, 5);
    send(8'hFF, 8'hF7, 3'd0, 1'b1, 1'b0);
    send(8'hFE, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'hBF, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b1);
    drain();

    // Reset while a result is stalled at the output.
    out_ready = 1'b0;
    send(8'hF0, 8'hCC, 3'd7, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset mid-burst, then a fresh single-beat XOR burst must not see the old accumulator.
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_burst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h69, 1'b1, 1);
    send(8'h3C, 8'h55, 3'd2, 1'b1, 1'b1);
    drain();

    // Randomized bursts with input gaps and output backpressure.
    model_on = 1'b1;
    for (int bst = 0; bst < 80; bst++) begin
      bit acc;
      int len;
      int first_op;
      acc      = 1'($urandom);
      len      = acc ? 1 + int'($urandom_range(5)) : 1;
      first_op = acc ? acc_ops[$urandom_range(6)] : int'($urandom_range(7));
      for (int i = 0; i < len; i++) begin
        got     = 1'b0;
        in_data = 16'($urandom);
        op      = (i == 0) ? 3'(first_op) : 3'($urandom);
        acc_en  = (i == 0) ? acc : 1'($urandom);
        in_last = acc ? (i == len - 1) : 1'($urandom);
        for (int t = 0; t < 40 && !got; t++) begin
          in_valid  = ($urandom_range(3) != 0);
          out_ready = ($urandom_range(3) != 0);
          tick(got);
        end
        if (!got) check("rand_accept_timeout", in_valid && in_ready, 1);
      end
      in_valid = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
